ram_rr_arbiter: RTL and testbench

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter_pkg.sv | 17 +
 rtl/ram_rr_arbiter_rr_arb2.sv | 20 ++
 rtl/ram_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
package ram_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not granted last wins.
module rr_arb2
  import ram_rr_arbiter_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = '0;
    if (a_req && b_req) begin
      win = (last == REQ_B) ? 2'b01 : 2'b10;
    end else begin
      win = {b_req, a_req};
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Arbitrates two requesters onto one RAM port; each transaction runs IDLE->SETUP->ACCESS->HOLD.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_ack,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dataout
);

  state_t            state, state_nxt;
  logic              last, last_nxt;
  logic              lat_we, lat_we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] datain_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              read_nxt, write_nxt;
  logic [1:0]        win;

  rr_arb2 u_arb (
    .a_req (a_req),
    .b_req (b_req),
    .last  (last),
    .win   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= REQ_B;
      lat_we     <= 1'b0;
      ram_addr   <= '0;
      ram_datain <= '0;
      rdata      <= '0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      lat_we     <= lat_we_nxt;
      ram_addr   <= addr_nxt;
      ram_datain <= datain_nxt;
      rdata      <= rdata_nxt;
      ram_read   <= read_nxt;
      ram_write  <= write_nxt;
    end
  end

  // RAM strobes are registered, so each is computed for the state being entered.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    lat_we_nxt = lat_we;
    addr_nxt   = ram_addr;
    datain_nxt = ram_datain;
    rdata_nxt  = rdata;
    read_nxt   = 1'b0;
    write_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win != 2'b00) begin
          state_nxt = SETUP;
          if (win[1]) begin
            last_nxt   = REQ_B;
            lat_we_nxt = b_we;
            addr_nxt   = b_addr;
            datain_nxt = b_wdata;
            read_nxt   = !b_we;
          end else begin
            last_nxt   = REQ_A;
            lat_we_nxt = a_we;
            addr_nxt   = a_addr;
            datain_nxt = a_wdata;
            read_nxt   = !a_we;
          end
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
        read_nxt  = !lat_we;
        write_nxt = lat_we;
      end
      ACCESS: begin
        state_nxt = HOLD;
        if (!lat_we) rdata_nxt = ram_dataout;
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign a_gnt = busy && (last == REQ_A);
  assign b_gnt = busy && (last == REQ_B);
  assign a_ack = (state == HOLD) && (last == REQ_A);
  assign b_ack = (state == HOLD) && (last == REQ_B);

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: 16x4 RAM model, vector table, scoreboard of expected acks.
module tb_ram_rr_arbiter;
  import ram_rr_arbiter_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic          clk;
  logic          rst_n;
  logic          a_req, b_req, a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_ack, b_ack, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_datain;
  logic          ram_read, ram_write;
  logic [DW-1:0] ram_dataout;

  ram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .b_req       (b_req),
    .a_we        (a_we),
    .b_we        (b_we),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .a_wdata     (a_wdata),
    .b_wdata     (b_wdata),
    .a_gnt       (a_gnt),
    .b_gnt       (b_gnt),
    .a_ack       (a_ack),
    .b_ack       (b_ack),
    .rdata       (rdata),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_datain  (ram_datain),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_dataout (ram_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes on the rising edge of its strobe; output floats low when not read.
  logic [DW-1:0] mem [16];
  int unsigned   write_edges = 0;
  always @(posedge ram_write) begin
    mem[ram_addr] = ram_datain;
    write_edges++;
  end
  assign ram_dataout = ram_read ? mem[ram_addr] : '0;

  int unsigned cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    logic          who;
    logic          rd;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          ra, rb, wa, wb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    logic          who;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] model [16];
  vec_t          vecs [10];
  int unsigned   checks = 0;
  int unsigned   failures = 0;
  int unsigned   read_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {a_gnt, b_gnt, a_ack, b_ack, busy, ram_read, ram_write,
               ram_addr, ram_datain, rdata}, 32'd0);
  endtask

  function automatic vec_t mk(input logic ra, input logic rb, input logic wa, input logic wb,
                              input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                              input logic [DW-1:0] da, input logic [DW-1:0] db,
                              input logic who);
    vec_t v;
    v.ra = ra; v.rb = rb; v.wa = wa; v.wb = wb;
    v.aa = aa; v.ab = ab; v.da = da; v.db = db; v.who = who;
    return v;
  endfunction

  function automatic exp_t expect_txn(input logic who, input logic we,
                                      input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    exp_t e;
    e.who   = who;
    e.rd    = !we;
    e.rdata = model[ad];
    if (we) model[ad] = wd;
    return e;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ram_read) read_cycles++;
      chk("gnt_onehot", {31'd0, a_gnt & b_gnt}, 32'd0);
      chk("rd_wr_exclusive", {31'd0, ram_read & ram_write}, 32'd0);
      if (a_ack || b_ack) begin
        chk("ack_onehot", {31'd0, a_ack & b_ack}, 32'd0);
        chk("ack_has_gnt", {31'd0, a_ack ? a_gnt : b_gnt}, 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_who", {31'd0, b_ack}, {31'd0, e.who});
          if (e.rd) chk("rdata", {28'd0, rdata}, {28'd0, e.rdata});
        end
      end
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t          e;
    logic          rd;
    logic [AW-1:0] ad;
    int unsigned   we0, rc0, n;
    logic          got;
    ad = v.who ? v.ab : v.aa;
    e  = expect_txn(v.who, v.who ? v.wb : v.wa, ad, v.who ? v.db : v.da);
    rd = e.rd;
    sb.push_back(e);
    we0 = write_edges;
    rc0 = read_cycles;
    a_req = v.ra; a_we = v.wa; a_addr = v.aa; a_wdata = v.da;
    b_req = v.rb; b_we = v.wb; b_addr = v.ab; b_wdata = v.db;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("gnt_winner", {30'd0, b_gnt, a_gnt}, v.who ? 32'd2 : 32'd1);
        chk("ram_addr", {28'd0, ram_addr}, {28'd0, ad});
      end
      if (n == 2) chk("ram_write_access", {31'd0, ram_write}, {31'd0, !rd});
      if (a_ack || b_ack) got = 1'b1;
    end
    chk("ack_latency", n, 32'd3);
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("write_edges", write_edges - we0, rd ? 32'd0 : 32'd1);
    chk("read_cycles", read_cycles - rc0, rd ? 32'd0 + 2 : 32'd0);
    if (!rd) chk("mem_written", {28'd0, mem[ad]}, {28'd0, model[ad]});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned   we0, n, acks;
    int unsigned   cyc [4];
    vecs[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0,  4'b1010, 4'b0000, REQ_A);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0,  4'b0000, 4'b0000, REQ_A);
    vecs[2] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd6,  4'b0011, 4'b1100, REQ_B);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd5,  4'b0000, 4'b0000, REQ_A);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3,  4'b0000, 4'b0000, REQ_B);
    vecs[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd6,  4'b0111, 4'b0000, REQ_A);
    vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd10, 4'b0000, 4'b0001, REQ_B);
    vecs[7] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd10, 4'b0000, 4'b0000, REQ_B);
    vecs[8] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  4'b0110, 4'b0000, REQ_A);
    vecs[9] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9,  4'b0000, 4'b0000, REQ_B);

    for (int unsigned i = 0; i < 16; i++) begin
      mem[i]   = 4'(i) ^ 4'h5;
      model[i] = 4'(i) ^ 4'h5;
    end
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset during SETUP of a write: transaction is lost, pointer returns to B.
    we0 = write_edges;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 4'b1110;
    @(negedge clk);
    chk("rst_setup_gnt", {31'd0, a_gnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_outputs");
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst_held_outputs");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_write", write_edges - we0, 32'd0);
    chk("rst_mem7", {28'd0, mem[7]}, {28'd0, model[7]});
    chk("rst_sb_empty", sb.size(), 32'd0);

    // Both held for four grants: A,B,A,B, acks four cycles apart.
    sb.push_back(expect_txn(REQ_A, 1'b0, 4'd3, 4'd0));
    sb.push_back(expect_txn(REQ_B, 1'b0, 4'd10, 4'd0));
    sb.push_back(expect_txn(REQ_A, 1'b0, 4'd3, 4'd0));
    sb.push_back(expect_txn(REQ_B, 1'b0, 4'd10, 4'd0));
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd10;
    n = 0; acks = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (a_ack || b_ack) begin
        cyc[acks] = cycle;
        acks++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("tie4_acks", acks, 32'd4);
    for (int unsigned i = 1; i < 4; i++) chk("tie4_gap", cyc[i] - cyc[i-1], 32'd4);
    @(negedge clk);

    // B write to 15 with address/data changed mid-transaction.
    we0 = write_edges;
    sb.push_back(expect_txn(REQ_B, 1'b1, 4'd15, 4'b0101));
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd15; b_wdata = 4'b0101;
    repeat (2) @(negedge clk);
    chk("b_access_write", {31'd0, ram_write}, 32'd1);
    b_addr = 4'd0; b_wdata = 4'b1001;
    n = 0;
    while (!(a_ack || b_ack) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("b_ack_seen", {31'd0, b_ack}, 32'd1);
    b_req = 1'b0;
    @(negedge clk);
    chk("b_mem15", {28'd0, mem[15]}, {28'd0, model[15]});
    chk("b_mem0", {28'd0, mem[0]}, {28'd0, model[0]});
    chk("b_write_edges", write_edges - we0, 32'd1);

    // A holds req across ack: back-to-back, then B joins and wins the tie.
    sb.push_back(expect_txn(REQ_A, 1'b1, 4'd2, 4'b0010));
    sb.push_back(expect_txn(REQ_A, 1'b1, 4'd2, 4'b0010));
    sb.push_back(expect_txn(REQ_B, 1'b0, 4'd2, 4'd0));
    sb.push_back(expect_txn(REQ_A, 1'b1, 4'd2, 4'b0010));
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 4'b0010;
    n = 0; acks = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (a_ack || b_ack) begin
        cyc[acks] = cycle;
        acks++;
        if (acks == 2) begin
          b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("hold_acks", acks, 32'd4);
    for (int unsigned i = 1; i < 4; i++) chk("hold_gap", cyc[i] - cyc[i-1], 32'd4);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
